nb_sram_arbiter: RTL

//  Two-requester arbiter sharing the single-port NB SRAM macro: the AHB_NB slave (M0) and a DMA/debug master (M1).
//  - Issues at most one SRAM access per HCLK and routes the 1-cycle-latency read data back to the owner.
//  - Default policy is round-robin.
//  - Sits between the requesters and the NBSRAM* pins of N15_SoC.

---
 rtl/nb_sram_arbiter_if.sv | 45 ++++
 rtl/nb_sram_arbiter.sv | 96 +++++++++
 2 files changed

// File: rtl/nb_sram_arbiter_if.sv
// Bus bundle between the two NB SRAM requesters, the arbiter and the SRAM macro pins.
// slave = arbiter side; master = requesters plus SRAM model side.
interface nb_sram_arbiter_if #(
  parameter int unsigned AW = 14
) ();
  logic          m0_req;
  logic [3:0]    m0_wen;
  logic [AW-3:0] m0_addr;
  logic [31:0]   m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [31:0]   m0_rdata;

  logic          m1_req;
  logic [3:0]    m1_wen;
  logic [AW-3:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [31:0]   m1_rdata;

  logic [31:0]   sramrdata;
  logic [3:0]    sramwen;
  logic [31:0]   sramwdata;
  logic          sramcs;
  logic [AW-3:0] sramaddr;

  modport slave (
    input  m0_req, m0_wen, m0_addr, m0_wdata,
    input  m1_req, m1_wen, m1_addr, m1_wdata,
    input  sramrdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output sramwen, sramwdata, sramcs, sramaddr
  );

  modport master (
    output m0_req, m0_wen, m0_addr, m0_wdata,
    output m1_req, m1_wen, m1_addr, m1_wdata,
    output sramrdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  sramwen, sramwdata, sramcs, sramaddr
  );
endinterface

// File: rtl/nb_sram_arbiter.sv
// Two-requester arbiter for the single-port NB SRAM: one access per cycle, 1-cycle read return.
// Round-robin by default; define NB_SRAM_ARB_QOS_EN for M0-priority with M1 anti-starvation.
module nb_sram_arbiter #(
  parameter int unsigned AW = 14
`ifdef NB_SRAM_ARB_QOS_EN
  ,
  parameter int unsigned MAX_WAIT = 4
`endif
) (
  input  logic            hclk,
  input  logic            hresetn,
  nb_sram_arbiter_if.slave bus
);

  logic gnt0, gnt1;
  logic rvalid0_q, rvalid1_q;
  logic [3:0]    wen_sel;
  logic [AW-3:0] addr_sel;
  logic [31:0]   wdata_sel;

`ifdef NB_SRAM_ARB_QOS_EN
  logic [3:0] wait_cnt_q;
`else
  logic last_gnt_q;
`endif

  // Grants are gated by reset so nothing reaches the SRAM while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (hresetn) begin
      if (bus.m0_req && bus.m1_req) begin
`ifdef NB_SRAM_ARB_QOS_EN
        if (wait_cnt_q == 4'(MAX_WAIT)) gnt1 = 1'b1;
        else                            gnt0 = 1'b1;
`else
        if (last_gnt_q) gnt0 = 1'b1;
        else            gnt1 = 1'b1;
`endif
      end else begin
        gnt0 = bus.m0_req;
        gnt1 = bus.m1_req;
      end
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
`ifdef NB_SRAM_ARB_QOS_EN
      wait_cnt_q <= '0;
`else
      last_gnt_q <= 1'b1;
`endif
    end else begin
      rvalid0_q <= gnt0 && (bus.m0_wen == 4'b0000);
      rvalid1_q <= gnt1 && (bus.m1_wen == 4'b0000);
`ifdef NB_SRAM_ARB_QOS_EN
      // Cannot pass MAX_WAIT: at MAX_WAIT a waiting M1 always wins.
      if (bus.m1_req && !gnt1) wait_cnt_q <= wait_cnt_q + 4'd1;
      else                     wait_cnt_q <= '0;
`else
      if (gnt0)      last_gnt_q <= 1'b0;
      else if (gnt1) last_gnt_q <= 1'b1;
`endif
    end
  end

  always_comb begin
    wen_sel   = '0;
    addr_sel  = '0;
    wdata_sel = '0;
    if (gnt0) begin
      wen_sel   = bus.m0_wen;
      addr_sel  = bus.m0_addr;
      wdata_sel = bus.m0_wdata;
    end else if (gnt1) begin
      wen_sel   = bus.m1_wen;
      addr_sel  = bus.m1_addr;
      wdata_sel = bus.m1_wdata;
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata  = bus.sramrdata;
  assign bus.m1_rdata  = bus.sramrdata;
  assign bus.sramcs    = gnt0 | gnt1;
  assign bus.sramwen   = wen_sel;
  assign bus.sramaddr  = addr_sel;
  assign bus.sramwdata = wdata_sel;

endmodule
